// File: rtl/psram_responder_if.sv
// ---------------------------------------------------------------------------
// psram_responder_if
// Serial PSRAM bus as seen by the responder, plus its status outputs.
//   i_psram_cs    chip select from the initiator, active low, async to clk
//   i_psram_sclk  serial clock from the initiator, async to clk
//   i_psram_data  8 data lines as driven by the initiator
//   o_psram_data  read data toward the initiator
//   o_psram_oe    high while o_psram_data should drive the shared lines
//   o_busy        high while a transaction is in progress
//   o_badCmd      one-clk pulse on an unsupported command byte
// Modports: slave = responder side, master = initiator / parent side.
// ---------------------------------------------------------------------------
interface psram_responder_if;
    logic       i_psram_cs;
    logic       i_psram_sclk;
    logic [7:0] i_psram_data;
    logic [7:0] o_psram_data;
    logic       o_psram_oe;
    logic       o_busy;
    logic       o_badCmd;

    modport slave (
        input  i_psram_cs, i_psram_sclk, i_psram_data,
        output o_psram_data, o_psram_oe, o_busy, o_badCmd
    );

    modport master (
        output i_psram_cs, i_psram_sclk, i_psram_data,
        input  o_psram_data, o_psram_oe, o_busy, o_badCmd
    );
endinterface

// File: rtl/psram_responder.sv
// ---------------------------------------------------------------------------
// psram_responder
// Byte-wide serial PSRAM target model. Accepts write (0x02) and read (0x03)
// commands followed by a 24-bit MSB-first address, then streams data bytes
// with auto-incrementing, wrapping addresses. Reads insert LATENCY dummy
// sclk edges before the first data byte. The bus is oversampled by clk.
//   clk    system clock, at least 4x the serial clock
//   reset  asynchronous, active-high
//   bus    psram_responder_if.slave (cs, sclk, data in; data, oe, busy,
//          badCmd out)
// Parameters:
//   ADDR_W   implemented address bits (2^ADDR_W bytes), at most 24
//   LATENCY  dummy sclk rising edges between address and first read byte
// ---------------------------------------------------------------------------
module psram_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 6
) (
    input  logic              clk,
    input  logic              reset,
    psram_responder_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, LAT, WRITE, READ, IGNORE} state_t;

    localparam int CNT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;

    // Synchronizers: data gets the same two stages as sclk so that the byte
    // seen at a detected edge is the one the initiator presented for it.
    logic       cs_s1, cs_s2;
    logic       sclk_s1, sclk_s2, sclk_prev;
    logic [7:0] data_s1, data_s2;

    state_t              state, state_nxt;
    logic                armed;       // cs seen high since reset
    logic [1:0]          byte_cnt;
    logic [15:0]         addr_hi;
    logic [23:0]         addr_full;
    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    dummy;
    logic                is_write;
    logic [7:0]          rd_data;
    logic                bad_cmd;
    logic [7:0]          mem [2**ADDR_W];

    logic rise, go, cmd_ok, last_addr, last_dummy;
    logic unused_addr_bits;

    assign rise       = sclk_s2 & ~sclk_prev;
    // A cs deassertion seen on the same clk as an edge wins over the edge.
    assign go         = rise & ~cs_s2;
    assign addr_full  = {addr_hi, data_s2};
    assign cmd_ok     = (data_s2 == 8'h02) || (data_s2 == 8'h03);
    assign last_addr  = (state == ADDR) && go && (byte_cnt == 2'd2);
    assign last_dummy = (state == LAT) && go && (dummy == CNT_W'(LAT_LAST));
    assign unused_addr_bits = ^addr_full[23:ADDR_W];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_s1     <= 1'b0;
            cs_s2     <= 1'b0;
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            data_s1   <= 8'h00;
            data_s2   <= 8'h00;
        end else begin
            cs_s1     <= bus.i_psram_cs;
            cs_s2     <= cs_s1;
            sclk_s1   <= bus.i_psram_sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            data_s1   <= bus.i_psram_data;
            data_s2   <= data_s1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        state_nxt = state;
        if (cs_s2) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (armed) state_nxt = CMD;
                CMD:  if (go) state_nxt = cmd_ok ? ADDR : IGNORE;
                ADDR: if (last_addr)
                          state_nxt = is_write ? WRITE : ((LATENCY == 0) ? READ : LAT);
                LAT:  if (last_dummy) state_nxt = READ;
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        bus.o_busy     = (state != IDLE);
        bus.o_psram_oe = (state == READ);
    end

    assign bus.o_psram_data = rd_data;
    assign bus.o_badCmd     = bad_cmd;

    // Datapath: command decode, address collection, dummy count, read load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed    <= 1'b0;
            byte_cnt <= 2'd0;
            addr_hi  <= 16'h0000;
            addr     <= '0;
            dummy    <= '0;
            is_write <= 1'b0;
            rd_data  <= 8'h00;
            bad_cmd  <= 1'b0;
        end else begin
            bad_cmd <= 1'b0;
            if (cs_s2) armed <= 1'b1;

            if (cs_s2 || state == IDLE) begin
                byte_cnt <= 2'd0;
                addr_hi  <= 16'h0000;
                dummy    <= '0;
            end else if (go) begin
                case (state)
                    CMD: begin
                        is_write <= (data_s2 == 8'h02);
                        bad_cmd  <= ~cmd_ok;
                    end
                    ADDR: begin
                        addr_hi  <= {addr_hi[7:0], data_s2};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2) begin
                            dummy <= '0;
                            if (!is_write && LATENCY == 0) begin
                                rd_data <= mem[addr_full[ADDR_W-1:0]];
                                addr    <= addr_full[ADDR_W-1:0] + 1'b1;
                            end else begin
                                addr    <= addr_full[ADDR_W-1:0];
                            end
                        end
                    end
                    LAT: begin
                        dummy <= dummy + 1'b1;
                        if (dummy == CNT_W'(LAT_LAST)) begin
                            rd_data <= mem[addr];
                            addr    <= addr + 1'b1;
                        end
                    end
                    WRITE: addr <= addr + 1'b1;
                    READ: begin
                        rd_data <= mem[addr];
                        addr    <= addr + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the storage array has no reset; its contents must survive reset
    // and a reset on a RAM would also prevent RAM inference.
    always_ff @(posedge clk) begin
        if (state == WRITE && go) mem[addr] <= data_s2;
    end

endmodule

// File: tb/tb_psram_responder.sv
// ---------------------------------------------------------------------------
// tb_psram_responder
// Directed bench for psram_responder (ADDR_W=16, LATENCY=6). The initiator
// runs sclk at exactly clk/4 with a random even-ns phase offset so bus
// transitions never coincide with a clk edge.
// ---------------------------------------------------------------------------
module tb_psram_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    psram_responder_if bus();

    psram_responder #(.ADDR_W(16), .LATENCY(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] wr_buf [4];
    logic [7:0] rd_buf [4];
    logic       rd_oe  [4];

    int   bad_cnt = 0;
    logic oe_seen = 1'b0;

    always @(negedge clk) begin
        if (bus.o_badCmd)   bad_cnt = bad_cnt + 1;
        if (bus.o_psram_oe) oe_seen = 1'b1;
    end

    // ---------------- bus primitives ----------------
    task automatic cs_low();
        #(2 * $urandom_range(0, 4));
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_cs   = 1'b0;
        #40;
    endtask

    task automatic cs_high();
        bus.i_psram_sclk = 1'b0;
        #20;
        bus.i_psram_cs = 1'b1;
        #60;
    endtask

    // One sclk period (40 ns = 4 clk): data changes while sclk is low.
    task automatic pulse(input logic [7:0] d);
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_data = d;
        #20;
        bus.i_psram_sclk = 1'b1;
        #20;
    endtask

    task automatic send_addr(input logic [23:0] a);
        pulse(a[23:16]);
        pulse(a[15:8]);
        pulse(a[7:0]);
    endtask

    task automatic write_burst(input logic [23:0] a, input int n);
        cs_low();
        pulse(8'h02);
        send_addr(a);
        for (int i = 0; i < n; i++) pulse(wr_buf[i]);
        cs_high();
    endtask

    // Samples each byte just before the sclk rising edge that follows the
    // edge which loaded it.
    task automatic read_burst(input logic [23:0] a, input int n);
        cs_low();
        pulse(8'h03);
        send_addr(a);
        for (int i = 0; i < 6; i++) pulse(8'h00);
        for (int i = 0; i < n; i++) begin
            bus.i_psram_sclk = 1'b0;
            #18;
            rd_buf[i] = bus.o_psram_data;
            rd_oe[i]  = bus.o_psram_oe;
            #2;
            bus.i_psram_sclk = 1'b1;
            #20;
        end
        cs_high();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.i_psram_cs   = 1'b1;
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_data = 8'h00;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.o_psram_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", bus.o_psram_oe); end
        checks++; if (bus.o_psram_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.o_psram_data); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
        checks++; if (bus.o_badCmd !== 1'b0) begin errors++; $display("FAIL reset_badcmd got %b want 0", bus.o_badCmd); end
        reset = 1'b0;
        #(2 * $urandom_range(1, 5));
        #60;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", bus.o_busy); end
    endtask

    task automatic test_write_read();
        wr_buf[0] = 8'h79;
        write_burst(24'h00C000, 1);
        read_burst(24'h00C000, 1);
        checks++; if (rd_buf[0] !== 8'h79) begin errors++; $display("FAIL wr_rd_data got %h want 79", rd_buf[0]); end
        checks++; if (rd_oe[0] !== 1'b1) begin errors++; $display("FAIL wr_rd_oe got %b want 1", rd_oe[0]); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] exp [3];
        exp[0] = 8'hAA; exp[1] = 8'hBB; exp[2] = 8'hCC;
        for (int i = 0; i < 3; i++) wr_buf[i] = exp[i];
        write_burst(24'h00FFFE, 3);
        read_burst(24'h00FFFE, 3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h want %h", i, rd_buf[i], exp[i]); end
            checks++; if (rd_oe[i] !== 1'b1) begin errors++; $display("FAIL wrap_oe[%0d] got %b want 1", i, rd_oe[i]); end
        end
        read_burst(24'h000000, 1);
        checks++; if (rd_buf[0] !== 8'hCC) begin errors++; $display("FAIL wrap_addr0 got %h want cc", rd_buf[0]); end
    endtask

    task automatic test_bad_cmd();
        bad_cnt = 0;
        oe_seen = 1'b0;
        cs_low();
        pulse(8'h9F);
        pulse(8'h00); pulse(8'hC0); pulse(8'h00); pulse(8'h5A);
        checks++; if (bus.o_busy !== 1'b1) begin errors++; $display("FAIL bad_busy_high got %b want 1", bus.o_busy); end
        bus.i_psram_sclk = 1'b0;
        #20;
        bus.i_psram_cs = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL bad_busy_fall got %b want 0", bus.o_busy); end
        #40;
        checks++; if (bad_cnt !== 1) begin errors++; $display("FAIL bad_pulse_width got %0d want 1", bad_cnt); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL bad_oe got %b want 0", oe_seen); end
        read_burst(24'h00C000, 1);
        checks++; if (rd_buf[0] !== 8'h79) begin errors++; $display("FAIL bad_mem got %h want 79", rd_buf[0]); end
    endtask

    task automatic test_abort();
        cs_low();
        pulse(8'h02);
        pulse(8'h00);
        pulse(8'hC0);
        cs_high();
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.o_busy); end
        read_burst(24'h00C000, 1);
        checks++; if (rd_buf[0] !== 8'h79) begin errors++; $display("FAIL abort_mem got %h want 79", rd_buf[0]); end
    endtask

    // cs rises on the same instant as an sclk rising edge during WRITE.
    task automatic test_cs_priority();
        wr_buf[0] = 8'h11;
        write_burst(24'h000100, 1);
        cs_low();
        pulse(8'h02);
        send_addr(24'h000100);
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_data = 8'h55;
        #20;
        bus.i_psram_sclk = 1'b1;
        bus.i_psram_cs   = 1'b1;
        #60;
        bus.i_psram_sclk = 1'b0;
        #20;
        read_burst(24'h000100, 1);
        checks++; if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL cs_priority got %h want 11", rd_buf[0]); end
    endtask

    task automatic test_reset_mid_read();
        cs_low();
        pulse(8'h03);
        send_addr(24'h00FFFE);
        for (int i = 0; i < 6; i++) pulse(8'h00);
        bus.i_psram_sclk = 1'b0;
        #18;
        checks++; if (bus.o_psram_oe !== 1'b1) begin errors++; $display("FAIL rst_read_oe_before got %b want 1", bus.o_psram_oe); end
        reset = 1'b1;
        #1;
        checks++; if (bus.o_psram_oe !== 1'b0) begin errors++; $display("FAIL rst_read_oe got %b want 0", bus.o_psram_oe); end
        checks++; if (bus.o_psram_data !== 8'h00) begin errors++; $display("FAIL rst_read_data got %h want 00", bus.o_psram_data); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_read_busy got %b want 0", bus.o_busy); end
        #21;
        reset = 1'b0;
        // cs still low after release: no transaction may start yet.
        #80;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL rst_wait_cs got %b want 0", bus.o_busy); end
        cs_high();
        read_burst(24'h00FFFE, 2);
        checks++; if (rd_buf[0] !== 8'hAA) begin errors++; $display("FAIL rst_mem0 got %h want aa", rd_buf[0]); end
        checks++; if (rd_buf[1] !== 8'hBB) begin errors++; $display("FAIL rst_mem1 got %h want bb", rd_buf[1]); end
    endtask

    initial begin
        bus.i_psram_cs   = 1'b1;
        bus.i_psram_sclk = 1'b0;
        bus.i_psram_data = 8'h00;
        #(2 * $urandom_range(0, 4));
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_bad_cmd();
        test_abort();
        test_cs_priority();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
